basilisk_issue_scoreboard: RTL and testbench
============================================

BASILISK_ISSUE_SCOREBOARD -- requirements
Module: basilisk_issue_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 16, range 1..31, max outstanding register writes.
REQ-002 SHALL have ports clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have in_valid/in_ready  in/out  1/1  decoded FP instruction handshake.
REQ-005 SHALL have in_rd, in_rs1, in_rs2, in_rs3  in  5 each  register indices.
REQ-006 SHALL have in_dep_rd, in_dep_rs1, in_dep_rs2, in_dep_rs3  in  1 each  dependency flags from the decode dependency functions.
REQ-007 SHALL have in_wr  in  1  instruction writes FP rd.
REQ-008 SHALL have in_payload  in  32  opaque instruction word.
REQ-009 SHALL have out_valid/out_ready  out/in  1/1  issue handshake to FPU units.
REQ-010 SHALL have out_payload  out  32, out_rd  out  5, out_wr  out  1  registered issue fields.
REQ-011 SHALL have wb0_valid/wb0_rd, wb1_valid/wb1_rd  in  1/5 each  writeback retire ports, no ready.
REQ-012 SHALL have fence_req  in  1 and fence_ack  out  1  drain handshake.
REQ-013 SHALL have inflight  out  6  outstanding write count, and err  out  1  sticky protocol error.

Function
REQ-014 SHALL hold busy[31:0], one bit per FP register.
REQ-015 SHALL define hazard = OR over x in {rd,rs1,rs2,rs3} of (in_dep_x AND busy_eff[in_x]), where busy_eff = busy with bits retired this cycle by wb0/wb1 cleared (same-cycle bypass).
REQ-016 SHALL drive in_ready = state==RUN AND !hazard AND (!in_wr OR inflight<MAX_INFLIGHT) AND (!out_valid OR out_ready); combinational, not dependent on in_valid.
REQ-017 SHALL, on in_valid&in_ready, load out_payload/out_rd/out_wr and set out_valid next cycle; latency exactly 1 cycle.
REQ-018 SHALL clear out_valid on out_valid&out_ready with no new accept; output fields SHALL hold stable while out_valid&!out_ready.
REQ-019 SHALL set busy[in_rd] and increment inflight on accept with in_wr=1.
REQ-020 SHALL, per wbN_valid with busy[wbN_rd]=1, clear busy[wbN_rd] and decrement inflight by one.
REQ-021 SHALL let both ports retire in one cycle (inflight -2); if wb0_rd==wb1_rd, clear once, decrement once, set err.
REQ-022 SHALL, for wbN_valid on a non-busy register, leave busy/inflight unchanged and set err.
REQ-023 SHALL, on simultaneous set and clear of the same register, leave busy set; net inflight = +1 -retires.
REQ-024 SHALL keep err set until reset.
REQ-025 SHALL implement states RUN, DRAIN, ACK.
REQ-026 SHALL go RUN->DRAIN when fence_req=1; in_ready=0 in DRAIN and ACK.
REQ-027 SHALL go DRAIN->ACK when inflight==0 and out_valid==0 (post-update values).
REQ-028 SHALL assert fence_ack for exactly one cycle in ACK, then go ACK->RUN; fence_req SHALL be held until fence_ack, and fence_req=1 in ACK SHALL NOT restart DRAIN that cycle.
REQ-029 SHALL keep writeback retirement and output handshake active in every state.

Reset
REQ-030 SHALL, on rst=0, asynchronously force busy=0, inflight=0, out_valid=0, out_wr=0, out_rd=0, out_payload=0, err=0, fence_ack=0, state=RUN.
REQ-031 SHALL, on rst assertion mid-operation, discard held instruction and all pending writes; no retirement accounting SHALL survive reset.
REQ-032 SHALL drive in_ready=0 while rst=0.

Verification
REQ-033 Accept FADD rd=5 in_wr=1; next in_dep_rs1=1 rs1=5 -> in_ready=0 until wb0_valid rd=5, same-cycle accept via bypass, inflight 1->1.
REQ-034 Issue 16 writes to rd=0..15, out_ready=1, no writeback -> inflight=16, in_ready=0 for in_wr=1, in_ready=1 for in_wr=0 non-hazard instruction.
REQ-035 wb0 rd=3 and wb1 rd=7 both busy, same cycle -> both cleared, inflight -2, err=0; repeat with wb0_rd=wb1_rd=3 -> one decrement, err=1.
REQ-036 out_ready=0 with out_valid=1 -> in_ready=0, out_payload stable 5 cycles; out_ready=1 -> accept next instruction same cycle.
REQ-037 fence_req with inflight=2 -> in_ready=0, retire both, fence_ack high one cycle after inflight==0 and out_valid==0, then RUN.
REQ-038 Assert rst in DRAIN with inflight=3 -> all outputs reset values immediately, state RUN after release.

Source files
------------

// File: rtl/basilisk_issue_scoreboard.sv
// FP issue scoreboard: tracks busy destination registers, holds back dependent
// instructions, registers one instruction toward the FPU and supports a fence drain.
module basilisk_issue_scoreboard #(
    parameter int MAX_INFLIGHT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rs3,
    input  logic        in_dep_rd,
    input  logic        in_dep_rs1,
    input  logic        in_dep_rs2,
    input  logic        in_dep_rs3,
    input  logic        in_wr,
    input  logic [31:0] in_payload,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_payload,
    output logic [4:0]  out_rd,
    output logic        out_wr,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_rd,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_rd,
    input  logic        fence_req,
    output logic        fence_ack,
    output logic [5:0]  inflight,
    output logic        err
);

    typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

    state_t      state_reg, state_next;
    logic [31:0] busy_reg, busy_next, busy_eff;
    logic [31:0] clear_mask, set_mask;
    logic [5:0]  inflight_reg, inflight_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_payload_reg;
    logic [4:0]  out_rd_reg;
    logic        out_wr_reg;
    logic        err_reg;
    logic        retire0, retire1, dup_wb, err_event;
    logic        hazard, accept, accept_wr, fence_ack_c;

    // A duplicate writeback retires through port 0 only, so the register is counted once.
    assign dup_wb    = wb0_valid & wb1_valid & (wb0_rd == wb1_rd);
    assign retire0   = wb0_valid & busy_reg[wb0_rd];
    assign retire1   = wb1_valid & busy_reg[wb1_rd] & ~dup_wb;
    assign err_event = (wb0_valid & ~busy_reg[wb0_rd]) | (wb1_valid & ~busy_reg[wb1_rd]) | dup_wb;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            assign clear_mask[gi] = (retire0 && wb0_rd == 5'(gi)) || (retire1 && wb1_rd == 5'(gi));
            assign set_mask[gi]   = accept_wr && in_rd == 5'(gi);
        end
    endgenerate

    assign busy_eff = busy_reg & ~clear_mask;
    assign hazard   = (in_dep_rd  & busy_eff[in_rd])  | (in_dep_rs1 & busy_eff[in_rs1]) |
                      (in_dep_rs2 & busy_eff[in_rs2]) | (in_dep_rs3 & busy_eff[in_rs3]);

    assign in_ready = rst && state_reg == RUN && !hazard &&
                      (!in_wr || inflight_reg < 6'(MAX_INFLIGHT)) &&
                      (!out_valid_reg || out_ready);
    assign accept    = in_valid & in_ready;
    assign accept_wr = accept & in_wr;

    // A set wins over a same-cycle clear of the same register.
    assign busy_next      = busy_eff | set_mask;
    assign inflight_next  = inflight_reg + 6'(accept_wr) - 6'(retire0) - 6'(retire1);
    assign out_valid_next = accept | (out_valid_reg & ~out_ready);

    always_comb begin
        state_next  = state_reg;
        fence_ack_c = 1'b0;
        case (state_reg)
            RUN:     if (fence_req) state_next = DRAIN;
            DRAIN:   if (inflight_next == 6'd0 && !out_valid_next) state_next = ACK;
            ACK: begin
                fence_ack_c = 1'b1;
                state_next  = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RUN;
            busy_reg        <= '0;
            inflight_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_payload_reg <= '0;
            out_rd_reg      <= '0;
            out_wr_reg      <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= busy_next;
            inflight_reg  <= inflight_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_reg | err_event;
            if (accept) begin
                out_payload_reg <= in_payload;
                out_rd_reg      <= in_rd;
                out_wr_reg      <= in_wr;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_payload = out_payload_reg;
    assign out_rd      = out_rd_reg;
    assign out_wr      = out_wr_reg;
    assign inflight    = inflight_reg;
    assign err         = err_reg;
    assign fence_ack   = fence_ack_c;

endmodule

// File: tb/tb_basilisk_issue_scoreboard.sv
// Directed bench for basilisk_issue_scoreboard: linear steps with hand-computed
// expectations checked by immediate assertions.
module tb_basilisk_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rd, in_rs1, in_rs2, in_rs3;
    logic        in_dep_rd, in_dep_rs1, in_dep_rs2, in_dep_rs3;
    logic        in_wr;
    logic [31:0] in_payload;
    logic        out_valid, out_ready;
    logic [31:0] out_payload;
    logic [4:0]  out_rd;
    logic        out_wr;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic        fence_req, fence_ack;
    logic [5:0]  inflight;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    basilisk_issue_scoreboard #(.MAX_INFLIGHT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_dep_rd(in_dep_rd), .in_dep_rs1(in_dep_rs1), .in_dep_rs2(in_dep_rs2), .in_dep_rs3(in_dep_rs3),
        .in_wr(in_wr), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_rd(out_rd), .out_wr(out_wr),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
        .fence_req(fence_req), .fence_ack(fence_ack),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rd, input logic wr, input logic [31:0] pl);
        in_valid   = v;
        in_rd      = rd;
        in_wr      = wr;
        in_payload = pl;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rs3 = 5'd0;
        in_dep_rd = 1'b0; in_dep_rs1 = 1'b0; in_dep_rs2 = 1'b0; in_dep_rs3 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        set_instr(1'b1, 5'd1, 1'b0, 32'h1111_1111);
        out_ready = 1'b1;
        wb0_valid = 1'b0; wb0_rd = 5'd0; wb1_valid = 1'b0; wb1_rd = 5'd0;
        fence_req = 1'b0;

        // Reset state
        #2;
        $display("step: reset");
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fence_ack", 32'(fence_ack), 32'd0);
        chk("rst_out_payload", out_payload, 32'd0);
        tick(); tick();
        rst = 1'b1;
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);

        // RAW hazard resolved by same-cycle writeback bypass
        $display("step: accept rd=5 write");
        set_instr(1'b1, 5'd5, 1'b1, 32'hADD0_0005);
        #1;
        chk("raw_first_ready", 32'(in_ready), 32'd1);
        tick();
        chk("raw_out_valid", 32'(out_valid), 32'd1);
        chk("raw_out_payload", out_payload, 32'hADD0_0005);
        chk("raw_out_rd", 32'(out_rd), 32'd5);
        chk("raw_out_wr", 32'(out_wr), 32'd1);
        chk("raw_inflight1", 32'(inflight), 32'd1);
        set_instr(1'b1, 5'd6, 1'b1, 32'h0000_BEEF);
        in_rs1 = 5'd5; in_dep_rs1 = 1'b1;
        #1;
        chk("raw_blocked", 32'(in_ready), 32'd0);
        tick();
        chk("raw_still_blocked", 32'(in_ready), 32'd0);
        chk("raw_out_drained", 32'(out_valid), 32'd0);
        $display("step: wb0 rd=5 with dependent accept");
        wb0_valid = 1'b1; wb0_rd = 5'd5;
        #1;
        chk("raw_bypass_ready", 32'(in_ready), 32'd1);
        tick();
        chk("raw_bypass_inflight", 32'(inflight), 32'd1);
        chk("raw_bypass_payload", out_payload, 32'h0000_BEEF);
        chk("raw_bypass_rd", 32'(out_rd), 32'd6);
        chk("raw_bypass_err", 32'(err), 32'd0);
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        wb0_valid = 1'b0; wb1_valid = 1'b1; wb1_rd = 5'd6;
        tick();
        wb1_valid = 1'b0;
        chk("raw_retired", 32'(inflight), 32'd0);

        // Fill to MAX_INFLIGHT
        for (int r = 0; r < 16; r++) begin
            $display("step: issue write rd=%0d", r);
            set_instr(1'b1, 5'(r), 1'b1, 32'h1600_0000 + 32'(r));
            #1;
            chk("fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        chk("fill_inflight", 32'(inflight), 32'd16);
        set_instr(1'b0, 5'd20, 1'b1, 32'd0);
        #1;
        chk("full_wr_blocked", 32'(in_ready), 32'd0);
        set_instr(1'b0, 5'd20, 1'b0, 32'd0);
        in_rs1 = 5'd20; in_dep_rs1 = 1'b1;
        #1;
        chk("full_nowr_ready", 32'(in_ready), 32'd1);
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        tick();

        // Dual writeback
        $display("step: wb0 rd=3 wb1 rd=7");
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb1_valid = 1'b1; wb1_rd = 5'd7;
        tick();
        chk("dual_inflight", 32'(inflight), 32'd14);
        chk("dual_err", 32'(err), 32'd0);
        $display("step: wb0 rd=4 wb1 rd=4");
        wb0_rd = 5'd4; wb1_rd = 5'd4;
        tick();
        chk("dup_inflight", 32'(inflight), 32'd13);
        chk("dup_err", 32'(err), 32'd1);
        $display("step: wb0 rd=3 not busy");
        wb1_valid = 1'b0; wb0_rd = 5'd3;
        tick();
        chk("nonbusy_inflight", 32'(inflight), 32'd13);
        chk("err_sticky", 32'(err), 32'd1);
        for (int r = 0; r < 16; r++) begin
            if (r != 3 && r != 4 && r != 7) begin
                wb0_rd = 5'(r);
                tick();
            end
        end
        wb0_valid = 1'b0;
        chk("drain_all_inflight", 32'(inflight), 32'd0);

        // Output backpressure
        $display("step: backpressure");
        out_ready = 1'b0;
        set_instr(1'b1, 5'd9, 1'b0, 32'h3636_3636);
        tick();
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        in_payload = 32'h7777_7777;
        for (int c = 0; c < 5; c++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_payload_stable", out_payload, 32'h3636_3636);
            chk("bp_valid_stable", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_payload", out_payload, 32'h7777_7777);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Set and clear of the same register in one cycle
        $display("step: set/clear rd=10");
        set_instr(1'b1, 5'd10, 1'b1, 32'hA);
        tick();
        set_instr(1'b1, 5'd10, 1'b1, 32'hB);
        wb0_valid = 1'b1; wb0_rd = 5'd10;
        tick();
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        chk("setclr_inflight", 32'(inflight), 32'd1);
        tick();
        wb0_valid = 1'b0;
        chk("setclr_retired", 32'(inflight), 32'd0);

        // Fence drain
        $display("step: fence with inflight=2");
        set_instr(1'b1, 5'd1, 1'b1, 32'hF1);
        tick();
        set_instr(1'b1, 5'd2, 1'b1, 32'hF2);
        tick();
        chk("fence_pre_inflight", 32'(inflight), 32'd2);
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        fence_req = 1'b1;
        tick();
        set_instr(1'b1, 5'd12, 1'b0, 32'hF3);
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        chk("drain_no_ack", 32'(fence_ack), 32'd0);
        wb0_valid = 1'b1; wb0_rd = 5'd1; wb1_valid = 1'b1; wb1_rd = 5'd2;
        tick();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        chk("ack_inflight", 32'(inflight), 32'd0);
        chk("ack_fence_ack", 32'(fence_ack), 32'd1);
        chk("ack_in_ready", 32'(in_ready), 32'd0);
        tick();
        fence_req = 1'b0;
        #1;
        chk("post_ack_low", 32'(fence_ack), 32'd0);
        chk("post_ack_ready", 32'(in_ready), 32'd1);
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);

        // Asynchronous reset in the middle of a drain
        $display("step: reset during drain inflight=3");
        for (int r = 20; r < 23; r++) begin
            set_instr(1'b1, 5'(r), 1'b1, 32'h3800_0000 + 32'(r));
            tick();
        end
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        chk("rd_pre_inflight", 32'(inflight), 32'd3);
        fence_req = 1'b1;
        tick();
        chk("rd_drain_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("rd_inflight", 32'(inflight), 32'd0);
        chk("rd_out_valid", 32'(out_valid), 32'd0);
        chk("rd_out_payload", out_payload, 32'd0);
        chk("rd_out_rd", 32'(out_rd), 32'd0);
        chk("rd_out_wr", 32'(out_wr), 32'd0);
        chk("rd_err", 32'(err), 32'd0);
        chk("rd_fence_ack", 32'(fence_ack), 32'd0);
        chk("rd_in_ready", 32'(in_ready), 32'd0);
        fence_req = 1'b0;
        tick();
        rst = 1'b1;
        set_instr(1'b1, 5'd20, 1'b1, 32'h5A5A_5A5A);
        in_dep_rd = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        tick();
        set_instr(1'b0, 5'd0, 1'b0, 32'd0);
        chk("post_rst_inflight", 32'(inflight), 32'd1);
        chk("post_rst_payload", out_payload, 32'h5A5A_5A5A);
        wb0_valid = 1'b1; wb0_rd = 5'd20;
        tick();
        wb0_valid = 1'b0;
        chk("post_rst_retire", 32'(inflight), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
